// File: rtl/mm_engine_pkg.sv
//------------------------------------------------------------------------------
// Module   : mm_engine_pkg
// Brief    : Shared state encoding and default sizes for the writeback path.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mm_engine_pkg;

  localparam int DEF_B_N                 = 2;
  localparam int DEF_B_MAX_MATRIX_LENGTH = 12;
  localparam int DEF_MEMORY_ADDRESS_BITS = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2
  } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/result_writeback_buffer_vector_fifo.sv
//------------------------------------------------------------------------------
// Module   : vector_fifo
// Brief    : Synchronous FIFO of whole result vectors with occupancy count.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vector_fifo #(
  parameter int WIDTH   = 128,
  parameter int B_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   push_data_i,
  input  logic               pop_i,
  output logic [WIDTH-1:0]   head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [B_DEPTH:0]   count_o
);

  localparam int DEPTH    = 1 << B_DEPTH;
  localparam int PTR_BITS = (B_DEPTH < 1) ? 1 : B_DEPTH;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [B_DEPTH:0]    count_q, count_d;
  logic                w_do_push, w_do_pop;

  function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
    return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + PTR_BITS'(1);
  endfunction

  assign full_o    = (count_q == (B_DEPTH + 1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (w_do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + (B_DEPTH + 1)'(1);
      2'b01:   count_d = count_q - (B_DEPTH + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/result_writeback_buffer.sv
//------------------------------------------------------------------------------
// Module   : result_writeback_buffer
// Brief    : Collects result vectors round-robin from the processors, buffers
//            them and streams them to RAM at sequential word addresses.
//            Optional macro RESULT_WRITEBACK_LAST_CHECK_EN adds last_error.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module result_writeback_buffer
  import mm_engine_pkg::*;
#(
  parameter int RESULT_WIDTH                   = 32,
  parameter int B_N                            = DEF_B_N,
  parameter int B_M                            = 2,
  parameter int B_NUM_PROCESSORS               = 2,
  parameter int B_PARALLEL_DATA_STREAMING_SIZE = 1,
  parameter int B_MAX_MATRIX_LENGTH            = DEF_B_MAX_MATRIX_LENGTH,
  parameter int MEMORY_ADDRESS_BITS            = DEF_MEMORY_ADDRESS_BITS,
  localparam int N                 = 1 << B_N,
  localparam int NUM_PROCESSORS    = 1 << B_NUM_PROCESSORS,
  localparam int P                 = 1 << B_PARALLEL_DATA_STREAMING_SIZE,
  localparam int MAX_MATRIX_LENGTH = 1 << B_MAX_MATRIX_LENGTH,
  localparam int COUNTER_BITS      = $clog2(MAX_MATRIX_LENGTH + 1),
  localparam int ID_BITS           = (B_NUM_PROCESSORS < 1) ? 1 : B_NUM_PROCESSORS
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             instruction_valid,
  output logic                                             instruction_ready,
  input  logic [MEMORY_ADDRESS_BITS-1:0]                   address_input,
  input  logic [COUNTER_BITS-1:0]                          length_input,
  input  logic [NUM_PROCESSORS-1:0]                        processor_output_valid,
  input  logic [NUM_PROCESSORS-1:0][N-1:0][RESULT_WIDTH-1:0] processor_output_data,
  input  logic [NUM_PROCESSORS-1:0]                        processor_output_last,
  output logic [NUM_PROCESSORS-1:0]                        processor_output_ready,
  output logic [MEMORY_ADDRESS_BITS-1:0]                   memory_write_address,
  output logic [P-1:0][RESULT_WIDTH-1:0]                   memory_write_data,
  output logic                                             memory_write_valid,
  input  logic                                             memory_write_ready,
  output logic                                             writeback_done
`ifdef RESULT_WRITEBACK_LAST_CHECK_EN
  ,
  output logic                                             last_error
`endif
);

  localparam int BEATS      = N / P;
  localparam int BEAT_BITS  = (B_N - B_PARALLEL_DATA_STREAMING_SIZE > 0) ?
                              (B_N - B_PARALLEL_DATA_STREAMING_SIZE) : 1;
  localparam int TOTAL_BITS = COUNTER_BITS + B_NUM_PROCESSORS;
  localparam int VEC_BITS   = N * RESULT_WIDTH;

  wb_state_e                      state_q, state_d;
  logic [MEMORY_ADDRESS_BITS-1:0] base_q, base_d;
  logic [MEMORY_ADDRESS_BITS-1:0] words_q, words_d;
  logic [TOTAL_BITS-1:0]          total_q, total_d;
  logic [TOTAL_BITS-1:0]          accepted_q, accepted_d;
  logic [ID_BITS-1:0]             id_q, id_d;
  logic [BEAT_BITS-1:0]           beat_q, beat_d;
  logic                           done_q, done_d;

  logic                           w_fifo_full, w_fifo_empty;
  logic [B_M:0]                   w_fifo_count;
  logic [BEATS-1:0][P*RESULT_WIDTH-1:0] w_head_beats;
  logic                           w_push, w_pop, w_beat_acc, w_beat_last;

  assign w_push      = (state_q == ST_COLLECT) && !w_fifo_full && processor_output_valid[id_q];
  assign w_beat_last = (beat_q == BEAT_BITS'(BEATS - 1));
  assign w_beat_acc  = memory_write_valid && memory_write_ready;
  assign w_pop       = w_beat_acc && w_beat_last;

  vector_fifo #(
    .WIDTH   (VEC_BITS),
    .B_DEPTH (B_M)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (w_push),
    .push_data_i (processor_output_data[id_q]),
    .pop_i       (w_pop),
    .head_o      (w_head_beats),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty),
    .count_o     (w_fifo_count)
  );

  assign instruction_ready    = (state_q == ST_IDLE);
  assign memory_write_valid   = !w_fifo_empty;
  assign memory_write_data    = w_head_beats[beat_q];
  assign memory_write_address = base_q + words_q;
  assign writeback_done       = done_q;

  for (genvar gi = 0; gi < NUM_PROCESSORS; gi++) begin : g_ready
    assign processor_output_ready[gi] = (state_q == ST_COLLECT) && !w_fifo_full &&
                                        (id_q == ID_BITS'(gi));
  end

`ifdef RESULT_WRITEBACK_LAST_CHECK_EN
  logic [COUNTER_BITS-1:0] length_q, length_d;
  logic                    last_error_q, last_error_d;
  logic [COUNTER_BITS-1:0] w_row;

  // Vectors arrive in full rounds, so the row is the push count over NUM_PROCESSORS.
  assign w_row      = accepted_q[TOTAL_BITS-1:B_NUM_PROCESSORS];
  assign last_error = last_error_q;

  always_comb begin
    length_d     = length_q;
    last_error_d = last_error_q;
    if (state_q == ST_IDLE && instruction_valid) begin
      length_d     = length_input;
      last_error_d = 1'b0;
    end else if (w_push &&
                 (processor_output_last[id_q] != (w_row == length_q - COUNTER_BITS'(1)))) begin
      last_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      length_q     <= '0;
      last_error_q <= 1'b0;
    end else begin
      length_q     <= length_d;
      last_error_q <= last_error_d;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = ^processor_output_last;
`endif

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    words_d    = words_q;
    total_d    = total_q;
    accepted_d = accepted_q;
    id_d       = id_q;
    beat_d     = beat_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (instruction_valid) begin
          base_d     = address_input;
          total_d    = TOTAL_BITS'(length_input) << B_NUM_PROCESSORS;
          accepted_d = '0;
          id_d       = '0;
          words_d    = '0;
          beat_d     = '0;
          if (length_input == '0) done_d  = 1'b1;
          else                    state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (w_push && (accepted_q + TOTAL_BITS'(1) == total_q)) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // No pushes happen here, so popping the only entry ends the command.
        if (w_pop && (w_fifo_count == (B_M + 1)'(1))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_push) begin
      accepted_d = accepted_q + TOTAL_BITS'(1);
      id_d       = (id_q == ID_BITS'(NUM_PROCESSORS - 1)) ? '0 : id_q + ID_BITS'(1);
    end

    if (w_beat_acc) begin
      words_d = words_q + MEMORY_ADDRESS_BITS'(P);
      beat_d  = w_beat_last ? '0 : beat_q + BEAT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      words_q    <= '0;
      total_q    <= '0;
      accepted_q <= '0;
      id_q       <= '0;
      beat_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      words_q    <= words_d;
      total_q    <= total_d;
      accepted_q <= accepted_d;
      id_q       <= id_d;
      beat_q     <= beat_d;
      done_q     <= done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_result_writeback_buffer.sv
//------------------------------------------------------------------------------
// Module   : tb_result_writeback_buffer
// Brief    : Randomized self-checking bench for result_writeback_buffer.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_result_writeback_buffer;

  localparam int RW = 32, B_N = 2, B_M = 2, B_NP = 2, B_P = 1, B_ML = 12, AW = 64;
  localparam int N = 1 << B_N, NP = 1 << B_NP, P = 1 << B_P, BEATS = N / P;
  localparam int CB = $clog2((1 << B_ML) + 1);

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       instruction_valid;
  logic                       instruction_ready;
  logic [AW-1:0]              address_input;
  logic [CB-1:0]              length_input;
  logic [NP-1:0]              processor_output_valid;
  logic [NP-1:0][N-1:0][RW-1:0] processor_output_data;
  logic [NP-1:0]              processor_output_last;
  logic [NP-1:0]              processor_output_ready;
  logic [AW-1:0]              memory_write_address;
  logic [P-1:0][RW-1:0]       memory_write_data;
  logic                       memory_write_valid;
  logic                       memory_write_ready;
  logic                       writeback_done;
`ifdef RESULT_WRITEBACK_LAST_CHECK_EN
  logic                       last_error;
`endif

  always #5 clk = ~clk;

  result_writeback_buffer #(
    .RESULT_WIDTH                   (RW),
    .B_N                            (B_N),
    .B_M                            (B_M),
    .B_NUM_PROCESSORS               (B_NP),
    .B_PARALLEL_DATA_STREAMING_SIZE (B_P),
    .B_MAX_MATRIX_LENGTH            (B_ML),
    .MEMORY_ADDRESS_BITS            (AW)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .instruction_valid      (instruction_valid),
    .instruction_ready      (instruction_ready),
    .address_input          (address_input),
    .length_input           (length_input),
    .processor_output_valid (processor_output_valid),
    .processor_output_data  (processor_output_data),
    .processor_output_last  (processor_output_last),
    .processor_output_ready (processor_output_ready),
    .memory_write_address   (memory_write_address),
    .memory_write_data      (memory_write_data),
    .memory_write_valid     (memory_write_valid),
    .memory_write_ready     (memory_write_ready),
    .writeback_done         (writeback_done)
`ifdef RESULT_WRITEBACK_LAST_CHECK_EN
    ,
    .last_error             (last_error)
`endif
  );

  typedef struct packed {
    logic [AW-1:0]        addr;
    logic [P-1:0][RW-1:0] data;
  } beat_t;

  beat_t                exp_q[$];
  int                   tests_run = 0;
  int                   fails = 0;
  bit                   busy = 0, done_next = 0, done_seen = 0, cmd_acc = 0, le_exp = 0;
  bit                   hold_valid = 0;
  logic [AW-1:0]        hold_addr, first_addr, last_addr;
  logic [P-1:0][RW-1:0] hold_data;
  int                   pushed = 0, total = 0, len_cur = 0, beats_acc = 0;
  int unsigned          cur_seed;
  logic [NP-1:0]        acc_mask = '0;
  logic [NP-1:0]        allowed;
  int                   next_row[NP];
  beat_t                cmp_b;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] vword(input int unsigned seed, input int id,
                                          input int row, input int w);
    return seed ^ {4'(id), 12'(row), 8'hA5, 8'(w)};
  endfunction

  // Reference: on every cycle compare outputs against the command-level model.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      busy = 0; done_next = 0; hold_valid = 0; acc_mask = '0; le_exp = 0;
    end else begin
      chk("done_pulse", writeback_done, done_next);
      if (writeback_done) done_seen = 1;
      done_next = 0;
      chk("instr_ready", instruction_ready, !busy);
      allowed = '0;
      if (busy && pushed < total) allowed[pushed % NP] = 1'b1;
      chk("ready_onehot", processor_output_ready & ~allowed, 0);
      if (!busy) chk("idle_wr_valid", memory_write_valid, 0);
      if (hold_valid) begin
        chk("hold_valid", memory_write_valid, 1);
        chk("hold_addr", memory_write_address, hold_addr);
        chk("hold_data", memory_write_data, hold_data);
      end
      hold_valid = memory_write_valid && !memory_write_ready;
      hold_addr  = memory_write_address;
      hold_data  = memory_write_data;
`ifdef RESULT_WRITEBACK_LAST_CHECK_EN
      chk("last_error", last_error, le_exp);
`endif
      if (memory_write_valid && memory_write_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          cmp_b = exp_q.pop_front();
          chk("beat_addr", memory_write_address, cmp_b.addr);
          chk("beat_data", memory_write_data, cmp_b.data);
          if (beats_acc == 0) first_addr = memory_write_address;
          last_addr = memory_write_address;
          beats_acc++;
          if (exp_q.size() == 0) begin
            busy = 0;
            done_next = 1;
          end
        end
      end
      for (int i = 0; i < NP; i++) begin
        if (processor_output_valid[i] && processor_output_ready[i]) begin
          acc_mask[i] = 1'b1;
`ifdef RESULT_WRITEBACK_LAST_CHECK_EN
          if (processor_output_last[i] != ((pushed / NP) == len_cur - 1)) le_exp = 1;
`endif
          pushed++;
        end
      end
      if (instruction_valid && instruction_ready) begin
        cmd_acc = 1;
        le_exp  = 0;
        if (len_cur == 0) done_next = 1;
        else              busy = 1;
      end
    end
  end

  task automatic idle_inputs();
    instruction_valid      = 1'b0;
    processor_output_valid = '0;
    processor_output_last  = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_cmd(input logic [AW-1:0] base, input int len, input int pv,
                         input int pr, input int stall, input int id2_only,
                         input int abort_at, input bit bad_last);
    int  cyc;
    bit  ended;
    int  row;
    bit  can;
    @(posedge clk); #1;
    cur_seed  = $urandom;
    len_cur   = len;
    total     = len * NP;
    pushed    = 0;
    beats_acc = 0;
    done_seen = 0;
    cmd_acc   = 0;
    for (int i = 0; i < NP; i++) next_row[i] = 0;
    exp_q.delete();
    for (int v = 0; v < total; v++) begin
      for (int b = 0; b < BEATS; b++) begin
        beat_t e;
        e.addr = base + AW'((v * BEATS + b) * P);
        for (int p = 0; p < P; p++) e.data[p] = vword(cur_seed, v % NP, v / NP, b * P + p);
        exp_q.push_back(e);
      end
    end
    address_input      = base;
    length_input       = CB'(len);
    instruction_valid  = 1'b1;
    memory_write_ready = (stall > 0) ? 1'b0 : 1'b1;
    cyc   = 0;
    ended = 0;
    while (!ended) begin
      @(posedge clk); #1;
      for (int i = 0; i < NP; i++) if (acc_mask[i]) next_row[i]++;
      acc_mask = '0;
      if (cmd_acc) instruction_valid = 1'b0;
      cyc++;
      if (stall > 0 && cyc == stall) begin
        chk("bp_pushed", pushed, 4);
        chk("bp_ready_zero", processor_output_ready, 0);
      end
      if (id2_only > 0 && cyc == id2_only) begin
        chk("ooo_pushed", pushed, 0);
        chk("ooo_ready2", processor_output_ready[2], 0);
      end
      if (done_seen) begin
        ended = 1;
      end else if (abort_at >= 0 && pushed >= abort_at) begin
        pulse_reset();
        @(negedge clk);
        chk("rst_wr_valid", memory_write_valid, 0);
        chk("rst_instr_ready", instruction_ready, 1);
        ended = 1;
      end else if (cyc > 3000) begin
        chk("timeout", 1, 0);
        pulse_reset();
        ended = 1;
      end else begin
        memory_write_ready = (cyc < stall) ? 1'b0 : ($urandom_range(99) < pr);
        for (int i = 0; i < NP; i++) begin
          row = next_row[i];
          can = (row < len) && (cyc >= id2_only || i == 2);
          processor_output_valid[i] = can && ($urandom_range(99) < pv);
          for (int w = 0; w < N; w++)
            processor_output_data[i][w] = can ? vword(cur_seed, i, row, w) : $urandom;
          processor_output_last[i] = can && ((row == len - 1) || (bad_last && i == 1 && row == 0));
        end
      end
    end
    idle_inputs();
    memory_write_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset                 = 1'b1;
    address_input         = '0;
    length_input          = '0;
    processor_output_data = '0;
    memory_write_ready    = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_instr_ready", instruction_ready, 1);
    chk("reset_proc_ready", processor_output_ready, 0);
    chk("reset_wr_valid", memory_write_valid, 0);
    chk("reset_done", writeback_done, 0);

    // Basic ordered writeback: 8 vectors, 16 beats from 0x100.
    run_cmd(64'h100, 2, 100, 100, 0, 0, -1, 0);
    chk("basic_beats", beats_acc, 16);
    chk("basic_first_addr", first_addr, 64'h100);
    chk("basic_last_addr", last_addr, 64'h11E);

    // Memory held off 20 cycles: FIFO fills to M and stops accepting.
    run_cmd(64'h2000, 2, 100, 100, 20, 0, -1, 0);
    chk("bp_beats", beats_acc, 16);

    // Only id2 valid at first: nothing may be pushed out of turn.
    run_cmd(64'h3000, 1, 100, 100, 0, 6, -1, 0);
    chk("ooo_beats", beats_acc, 8);

    // Zero-length command.
    run_cmd(64'h4000, 0, 100, 100, 0, 0, -1, 0);
    chk("len0_beats", beats_acc, 0);
    chk("len0_idle", instruction_ready, 1);

    // Reset in the middle of collection, then a fresh command.
    run_cmd(64'h5000, 3, 100, 100, 0, 0, 3, 0);
    run_cmd(64'h6000, 1, 100, 100, 0, 0, -1, 0);
    chk("post_rst_first_addr", first_addr, 64'h6000);
    chk("post_rst_beats", beats_acc, 8);

    // Address wrap at the top of the address space.
    run_cmd(64'hFFFF_FFFF_FFFF_FFFA, 1, 100, 100, 0, 0, -1, 0);
    chk("wrap_last_addr", last_addr, 64'h8);

`ifdef RESULT_WRITEBACK_LAST_CHECK_EN
    run_cmd(64'h7000, 2, 100, 100, 0, 0, -1, 1);
    chk("last_err_set", last_error, 1);
    run_cmd(64'h7100, 2, 100, 100, 0, 0, -1, 0);
    chk("last_err_clear", last_error, 0);
`endif

    for (int r = 0; r < 12; r++) begin
      run_cmd({$urandom, $urandom}, $urandom_range(1, 3), $urandom_range(30, 100),
              $urandom_range(30, 100), 0, 0, -1, 0);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

`default_nettype wire
